// File: rtl/serial_sub8.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin, one bit per clock.
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module serial_sub8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             borrow;
    logic [CW-1:0]    cnt;
`ifdef SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    logic x;
    logic y;
    logic d;
    logic nb;

    always_comb begin
        x  = sa[0];
        y  = sb[0];
        d  = x ^ y ^ borrow;
        nb = (~x & y) | (~(x ^ y) & borrow);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
`ifdef SUB_OVF_EN
            ovf    <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
`endif
        end else begin
            unique case (state)
                // DONE behaves like IDLE: busy is low, so a start is accepted
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa     <= a;
                        sb     <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
`ifdef SUB_OVF_EN
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    res    <= {d, res[WIDTH-1:1]};
                    borrow <= nb;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        diff  <= {d, res[WIDTH-1:1]};
                        bout  <= nb;
`ifdef SUB_OVF_EN
                        ovf   <= (a_msb != b_msb) && (d != a_msb);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub8.sv
// Directed and model-checked bench for serial_sub8 (WIDTH=8).
// Builds with or without SUB_OVF_EN.
module tb_serial_sub8;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SUB_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_sub8 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Raise start just after an edge (edge 0); return the number of edges
    // until done is seen high, or -1 if it never arrives.
    task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                         input logic ci, output int lat);
        lat = -1;
        @(posedge clk);
        #1;
        start = 1'b1;
        a = ai;
        b = bi;
        bin = ci;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                start = 1'b0;
                a = W'($urandom);
                b = W'($urandom);
                bin = 1'($urandom);
            end
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b diff=%h bout=%b, want 0 0 00 0",
                     busy, done, diff, bout);
        end
`ifdef SUB_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: ovf=%b, want 0", ovf);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [W-1:0] va [3] = '{8'h05, 8'h03, 8'h00};
        logic [W-1:0] vb [3] = '{8'h03, 8'h05, 8'h00};
        logic         vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [W-1:0] ed [3] = '{8'h02, 8'hFE, 8'hFF};
        logic         eb [3] = '{1'b0, 1'b1, 1'b1};
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], vc[i], lat);
            checks++;
            if (lat !== 9) begin
                errors++;
                $display("FAIL basic%0d_latency: got %0d, want 9", i, lat);
            end
            checks++;
            if (diff !== ed[i] || bout !== eb[i] || busy !== 1'b0) begin
                errors++;
                $display("FAIL basic%0d: diff=%h bout=%b busy=%b, want %h %b 0",
                         i, diff, bout, busy, ed[i], eb[i]);
            end
`ifdef SUB_OVF_EN
            checks++;
            if (ovf !== 1'b0) begin
                errors++;
                $display("FAIL basic%0d_ovf: ovf=%b, want 0", i, ovf);
            end
`endif
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || diff !== ed[i]) begin
                errors++;
                $display("FAIL basic%0d_hold: done=%b diff=%h, want 0 %h",
                         i, done, diff, ed[i]);
            end
        end
    endtask

    task automatic test_ovf();
        int lat;
        do_op(8'h80, 8'h01, 1'b0, lat);
        checks++;
        if (lat !== 9 || diff !== 8'h7F || bout !== 1'b0) begin
            errors++;
            $display("FAIL ovf_case: lat=%0d diff=%h bout=%b, want 9 7f 0",
                     lat, diff, bout);
        end
`ifdef SUB_OVF_EN
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: ovf=%b, want 1", ovf);
        end
`endif
    endtask

    task automatic test_ignore();
        int ndone = 0;
        int first = -1;
        @(posedge clk);
        #1;
        start = 1'b1;
        a = 8'h05;
        b = 8'h03;
        bin = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (first < 0) first = n;
            end
            start = (n == 3 || n == 5);
            a = 8'hFF;
            b = 8'h01;
        end
        start = 1'b0;
        checks++;
        if (ndone !== 1 || first !== 9 || diff !== 8'h02) begin
            errors++;
            $display("FAIL ignore_busy: dones=%0d at=%0d diff=%h, want 1 9 02",
                     ndone, first, diff);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va [3] = '{8'h10, 8'h20, 8'h30};
        logic [W-1:0] vb [3] = '{8'h01, 8'h02, 8'h03};
        logic [W-1:0] ed [3] = '{8'h0F, 8'h1E, 8'h2D};
        int k = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        a = va[0];
        b = vb[0];
        bin = 1'b0;
        for (int n = 1; n <= 40 && k < 3; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                checks++;
                if (n !== 9 * (k + 1) || diff !== ed[k] || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b%0d: edge=%0d diff=%h busy=%b, want %0d %h 0",
                             k, n, diff, busy, 9 * (k + 1), ed[k]);
                end
                k++;
                if (k < 3) begin
                    a = va[k];
                    b = vb[k];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (k !== 3) begin
            errors++;
            $display("FAIL b2b_count: dones=%0d, want 3", k);
        end
    endtask

    task automatic test_abort();
        int ndone = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        a = 8'h05;
        b = 8'h03;
        bin = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
            errors++;
            $display("FAIL abort: busy=%b done=%b diff=%h bout=%b, want 0 0 00 0",
                     busy, done, diff, bout);
        end
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL abort_nodone: dones=%0d, want 0", ndone);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   full;
        int lat;
        for (int i = 0; i < 300; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            full = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rc};
            do_op(ra, rb, rc, lat);
            checks++;
            if (lat !== 9 || diff !== full[W-1:0] || bout !== full[W]) begin
                errors++;
                $display("FAIL random%0d %h-%h-%b: lat=%0d diff=%h bout=%b, want 9 %h %b",
                         i, ra, rb, rc, lat, diff, bout, full[W-1:0], full[W]);
            end
`ifdef SUB_OVF_EN
            checks++;
            if (ovf !== ((ra[W-1] != rb[W-1]) && (full[W-1] != ra[W-1]))) begin
                errors++;
                $display("FAIL random%0d_ovf: ovf=%b", i, ovf);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ovf();
        test_ignore();
        test_back_to_back();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
